// File: rtl/spart_driver.sv
// rtl/spart_driver.sv - spart bus master: programs the baud divisor, then echoes received bytes
// Optional ECHO_CRLF_EN: a received CR is echoed as CR followed by LF.
module spart_driver #(
    parameter int CLK_FREQ = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    input  logic       rda,
    input  logic       tbr,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus
);

    localparam logic [15:0] DIV_4800  = 16'(CLK_FREQ / (16 * 4800) - 1);
    localparam logic [15:0] DIV_9600  = 16'(CLK_FREQ / (16 * 9600) - 1);
    localparam logic [15:0] DIV_19200 = 16'(CLK_FREQ / (16 * 19200) - 1);
    localparam logic [15:0] DIV_38400 = 16'(CLK_FREQ / (16 * 38400) - 1);

    localparam logic [1:0] ADDR_BUF    = 2'b00;
    localparam logic [1:0] ADDR_DIV_LO = 2'b10;
    localparam logic [1:0] ADDR_DIV_HI = 2'b11;

    // state names the bus cycle currently in progress; outputs are launched with the state
    typedef enum logic [2:0] {
        INIT_LO  = 3'd0,
        INIT_HI  = 3'd1,
        IDLE     = 3'd2,
        READ     = 3'd3,
        WAIT_TX  = 3'd4,
        WRITE    = 3'd5
`ifdef ECHO_CRLF_EN
        ,
        CR_LF    = 3'd6,
        LF_WRITE = 3'd7
`endif
    } state_t;

    state_t      state;
    logic [1:0]  br_reg;
    logic [7:0]  hold;
    logic [7:0]  data_out;
    logic        drive_en;
    logic [15:0] div_new;
    logic [15:0] div_cur;

    function automatic logic [15:0] div_of(input logic [1:0] sel);
        case (sel)
            2'b00:   return DIV_4800;
            2'b01:   return DIV_9600;
            2'b10:   return DIV_19200;
            default: return DIV_38400;
        endcase
    endfunction

    assign div_new = div_of(br_cfg);
    assign div_cur = div_of(br_reg);
    assign databus = drive_en ? data_out : 8'hzz;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= INIT_LO;
            iocs     <= 1'b0;
            iorw     <= 1'b1;
            ioaddr   <= ADDR_BUF;
            drive_en <= 1'b0;
            data_out <= 8'h00;
            hold     <= 8'h00;
            br_reg   <= 2'b00;
        end else begin
            iocs     <= 1'b0;
            iorw     <= 1'b1;
            ioaddr   <= ADDR_BUF;
            drive_en <= 1'b0;
            case (state)
                INIT_LO: begin
                    iocs     <= 1'b1;
                    iorw     <= 1'b0;
                    drive_en <= 1'b1;
                    // coming out of reset the low byte has not been launched yet
                    if (!iocs) begin
                        br_reg   <= br_cfg;
                        ioaddr   <= ADDR_DIV_LO;
                        data_out <= div_new[7:0];
                    end else begin
                        ioaddr   <= ADDR_DIV_HI;
                        data_out <= div_cur[15:8];
                        state    <= INIT_HI;
                    end
                end
                INIT_HI: state <= IDLE;
                IDLE: begin
                    if (br_cfg != br_reg) begin
                        br_reg   <= br_cfg;
                        iocs     <= 1'b1;
                        iorw     <= 1'b0;
                        drive_en <= 1'b1;
                        ioaddr   <= ADDR_DIV_LO;
                        data_out <= div_new[7:0];
                        state    <= INIT_LO;
                    end else if (rda) begin
                        iocs  <= 1'b1;
                        state <= READ;
                    end
                end
                READ: begin
                    hold  <= databus;
                    state <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (tbr) begin
                        iocs     <= 1'b1;
                        iorw     <= 1'b0;
                        drive_en <= 1'b1;
                        data_out <= hold;
                        state    <= WRITE;
                    end
                end
`ifdef ECHO_CRLF_EN
                WRITE: state <= (hold == 8'h0D) ? CR_LF : IDLE;
                CR_LF: begin
                    if (tbr) begin
                        iocs     <= 1'b1;
                        iorw     <= 1'b0;
                        drive_en <= 1'b1;
                        data_out <= 8'h0A;
                        state    <= LF_WRITE;
                    end
                end
                LF_WRITE: state <= IDLE;
`else
                WRITE: state <= IDLE;
`endif
                default: state <= INIT_LO;
            endcase
        end
    end

endmodule
